// File: rtl/dmem_responder.sv
// Data-memory responder: word array, read-latency counter and a
// single-entry response buffer behind valid/ready handshakes.
module dmem_responder #(
  parameter int ADDR_WIDTH   = 16,
  parameter int READ_LATENCY = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_addr_i,
  input  logic [3:0]  req_we_i,
  input  logic [3:0]  req_re_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o
);

  localparam int IW    = ADDR_WIDTH - 2;
  localparam int DEPTH = 2 ** IW;
  localparam logic [3:0] LAT_M1 = 4'(READ_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            err_q, err_d;

  logic [31:0]     mem_q [DEPTH];

  logic            accept;
  logic            in_range;
  logic            is_store;
  logic            is_load;
  logic            wr_en;
  logic [IW-1:0]   req_idx;
  logic            unused_bits;

  assign unused_bits = ^req_addr_i[1:0];

  assign req_idx  = req_addr_i[ADDR_WIDTH-1:2];
  assign in_range = (req_addr_i[31:ADDR_WIDTH] == '0);
  assign is_store = (req_we_i != 4'b0000);
  assign is_load  = (req_re_i != 4'b0000);
  assign accept   = req_valid_i && (state_q == IDLE);
  assign wr_en    = accept && in_range && is_store && !rst_i;

  assign req_ready_o  = (state_q == IDLE);
  assign resp_valid_o = (state_q == RESP);
  assign resp_rdata_o = rdata_q;
  assign resp_err_o   = err_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          idx_d   = req_idx;
          rdata_d = '0;
          err_d   = !in_range;
          // Stores win over loads; errors and nops answer at once
          if (!in_range || is_store || !is_load) begin
            state_d = RESP;
          end else if (READ_LATENCY == 1) begin
            state_d = RESP;
            rdata_d = mem_q[req_idx];
          end else begin
            state_d = WAIT;
            cnt_d   = LAT_M1;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd1) begin
          state_d = RESP;
          rdata_d = mem_q[idx_q];
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (resp_ready_i) begin
          state_d = IDLE;
          rdata_d = '0;
          err_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // The array is deliberately left out of reset
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (req_we_i[b]) begin
          mem_q[req_idx][8*b +: 8] <= req_wdata_i[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed testbench for dmem_responder (ADDR_WIDTH=16,
// READ_LATENCY=2); inputs change and outputs are sampled on negedge.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [3:0]  req_we;
  logic [3:0]  req_re;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dmem_responder #(
    .ADDR_WIDTH  (16),
    .READ_LATENCY(2)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_addr_i  (req_addr),
    .req_we_i    (req_we),
    .req_re_i    (req_re),
    .req_wdata_i (req_wdata),
    .resp_valid_o(resp_valid),
    .resp_ready_i(resp_ready),
    .resp_rdata_o(resp_rdata),
    .resp_err_o  (resp_err)
  );

  task automatic idle_inputs();
    req_valid = 1'b0;
    req_addr  = '0;
    req_we    = '0;
    req_re    = '0;
    req_wdata = '0;
  endtask

  // Present a request at a negedge; it is accepted at the next posedge
  // and withdrawn at the following negedge.
  task automatic send(input logic [31:0] a, input logic [3:0] we,
                      input logic [3:0] re, input logic [31:0] wd);
    req_valid = 1'b1;
    req_addr  = a;
    req_we    = we;
    req_re    = re;
    req_wdata = wd;
    @(negedge clk);
    idle_inputs();
  endtask

  // Called at the first negedge after accept; n = cycles until valid.
  task automatic wait_resp(output int n);
    n = 1;
    while (resp_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    resp_ready = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got=%b exp=1", req_ready);
    end
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid got=%b exp=0", resp_valid);
    end
    checks++;
    if (resp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_rdata got=%h exp=0", resp_rdata);
    end
    checks++;
    if (resp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_err got=%b exp=0", resp_err);
    end
  endtask

  task automatic test_store();
    int n;
    send(32'h10, 4'b1111, 4'b0000, 32'hDEADBEEF);
    wait_resp(n);
    checks++;
    if (n != 1) begin
      errors++;
      $display("FAIL store_latency got=%0d exp=1", n);
    end
    checks++;
    if (resp_rdata !== 32'h0 || resp_err !== 1'b0) begin
      errors++;
      $display("FAIL store_resp got=%h/%b exp=0/0",
               resp_rdata, resp_err);
    end
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL store_retire got=rdy%b/vld%b exp=1/0",
               req_ready, resp_valid);
    end
  endtask

  task automatic test_load();
    int n;
    send(32'h10, 4'b0000, 4'b1111, 32'h0);
    checks++;
    if (req_ready !== 1'b0 || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL load_wait got=rdy%b/vld%b exp=0/0",
               req_ready, resp_valid);
    end
    wait_resp(n);
    checks++;
    if (n != 2) begin
      errors++;
      $display("FAIL load_latency got=%0d exp=2", n);
    end
    checks++;
    if (resp_rdata !== 32'hDEADBEEF || resp_err !== 1'b0) begin
      errors++;
      $display("FAIL load_data got=%h/%b exp=deadbeef/0",
               resp_rdata, resp_err);
    end
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL load_ready_resp got=%b exp=0", req_ready);
    end
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL load_retire got=%b exp=1", req_ready);
    end
  endtask

  task automatic test_partial_store();
    int n;
    send(32'h12, 4'b1100, 4'b0000, 32'h12340000);
    wait_resp(n);
    checks++;
    if (n != 1 || resp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL pstore_resp got=%0d/%h exp=1/0", n, resp_rdata);
    end
    @(negedge clk);
    send(32'h10, 4'b0000, 4'b1111, 32'h0);
    wait_resp(n);
    checks++;
    if (n != 2 || resp_rdata !== 32'h1234BEEF) begin
      errors++;
      $display("FAIL pstore_load got=%0d/%h exp=2/1234beef",
               n, resp_rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int n;
    resp_ready = 1'b0;
    send(32'h10, 4'b0000, 4'b0011, 32'h0);
    wait_resp(n);
    checks++;
    if (n != 2) begin
      errors++;
      $display("FAIL bp_latency got=%0d exp=2", n);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (resp_valid !== 1'b1 || resp_rdata !== 32'h1234BEEF ||
          req_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d got=vld%b/%h/rdy%b exp=1/1234beef/0",
                 i, resp_valid, resp_rdata, req_ready);
      end
      @(negedge clk);
    end
    resp_ready = 1'b1;
    checks++;
    if (resp_valid !== 1'b1 || resp_rdata !== 32'h1234BEEF) begin
      errors++;
      $display("FAIL bp_sixth got=%b/%h exp=1/1234beef",
               resp_valid, resp_rdata);
    end
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_retire got=rdy%b/vld%b exp=1/0",
               req_ready, resp_valid);
    end
  endtask

  task automatic test_out_of_range();
    int n;
    send(32'h0, 4'b1111, 4'b0000, 32'hCAFEF00D);
    wait_resp(n);
    @(negedge clk);
    send(32'h0002_0000, 4'b1111, 4'b0000, 32'hFFFFFFFF);
    wait_resp(n);
    checks++;
    if (n != 1 || resp_err !== 1'b1 || resp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL oor_resp got=%0d/err%b/%h exp=1/1/0",
               n, resp_err, resp_rdata);
    end
    @(negedge clk);
    send(32'h0, 4'b0000, 4'b1111, 32'h0);
    wait_resp(n);
    checks++;
    if (n != 2 || resp_rdata !== 32'hCAFEF00D || resp_err !== 1'b0) begin
      errors++;
      $display("FAIL oor_word0 got=%0d/%h/%b exp=2/cafef00d/0",
               n, resp_rdata, resp_err);
    end
    @(negedge clk);
  endtask

  task automatic test_nop_and_both();
    int n;
    send(32'h20, 4'b0000, 4'b0000, 32'h0);
    wait_resp(n);
    checks++;
    if (n != 1 || resp_rdata !== 32'h0 || resp_err !== 1'b0) begin
      errors++;
      $display("FAIL nop_resp got=%0d/%h/%b exp=1/0/0",
               n, resp_rdata, resp_err);
    end
    @(negedge clk);
    send(32'h20, 4'b1111, 4'b1111, 32'h55AA55AA);
    wait_resp(n);
    checks++;
    if (n != 1 || resp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL both_resp got=%0d/%h exp=1/0", n, resp_rdata);
    end
    @(negedge clk);
    send(32'h20, 4'b0000, 4'b0001, 32'h0);
    wait_resp(n);
    checks++;
    if (n != 2 || resp_rdata !== 32'h55AA55AA) begin
      errors++;
      $display("FAIL both_load got=%0d/%h exp=2/55aa55aa",
               n, resp_rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int n;
    // Request held valid across the response; accepted again after retire
    req_valid = 1'b1;
    req_addr  = 32'h24;
    req_we    = 4'b1111;
    req_re    = 4'b0000;
    req_wdata = 32'h0BADF00D;
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b1 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first got=vld%b/rdy%b exp=1/0",
               resp_valid, req_ready);
    end
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_gap got=rdy%b/vld%b exp=1/0",
               req_ready, resp_valid);
    end
    req_we = 4'b0000;
    req_re = 4'b1111;
    @(negedge clk);
    idle_inputs();
    wait_resp(n);
    checks++;
    if (n != 2 || resp_rdata !== 32'h0BADF00D) begin
      errors++;
      $display("FAIL b2b_load got=%0d/%h exp=2/0badf00d",
               n, resp_rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_in_wait();
    bit seen;
    send(32'h10, 4'b0000, 4'b1111, 32'h0);
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL rstw_pre got=vld%b/rdy%b exp=0/0",
               resp_valid, req_ready);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL rstw_after got=vld%b/rdy%b exp=0/1",
               resp_valid, req_ready);
    end
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (resp_valid !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL rstw_ghost got=1 exp=0");
    end
  endtask

  initial begin
    rst = 1'b1;
    resp_ready = 1'b1;
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_store();
    test_load();
    test_partial_store();
    test_backpressure();
    test_out_of_range();
    test_nop_and_both();
    test_back_to_back();
    test_reset_in_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
